seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector. It samples one bit of `din` per qualified clock and compares the last `N` accepted bits against a run-time loadable pattern. It raises a registered one-cycle `d_out` pulse on each match and can count matches. Overlapping and non-overlapping detection are selectable at run time. It is the general-purpose successor to the fixed 4-bit Mealy detectors in the serial-protocol front ends.

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_detect_param_hist_shift.sv | 55 +++++
 rtl/seq_detect_param.sv | 109 ++++++++++
 tb/tb_seq_detect_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared constants and types for the parametrised serial pattern detector.
//   PAT_DEFAULT : pattern loaded at reset when the instantiator does not override it
//   N_MIN/N_MAX : legal range of the pattern length N
//   mode_e      : detection mode decoded from the overlap input
package seq_detect_pkg;

  localparam int unsigned N_MIN       = 2;
  localparam int unsigned N_MAX       = 32;
  localparam logic [3:0]  PAT_DEFAULT = 4'b1001;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_detect_param_hist_shift.sv
// seq_hist_shift
// N-bit history shift register plus a count of how many history bits are valid.
// Ports:
//   i_clk           : clock, rising edge
//   i_reset         : synchronous active-high reset (history and fill cleared)
//   i_shift         : shift i_din into the LSB of the history
//   i_clear         : zero the fill count (wins over i_shift for the count only)
//   i_din           : serial bit
//   o_hist          : current history, most recent bit in the LSB
//   o_full          : all N history bits are valid
//   o_full_on_shift : history will be full once the current shift lands
module seq_hist_shift #(
  parameter int unsigned N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_shift,
  input  logic         i_clear,
  input  logic         i_din,
  output logic [N-1:0] o_hist,
  output logic         o_full,
  output logic         o_full_on_shift
);

  localparam int unsigned FILL_W = $clog2(N + 1);

  logic [N-1:0]      r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              w_full;

  assign w_full = (r_fill == FILL_W'(N));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (i_shift) begin
        r_hist <= {r_hist[N-2:0], i_din};
      end
      // A clear on the same edge as a shift still shifts the bit in; only the
      // validity count restarts.
      if (i_clear) begin
        r_fill <= '0;
      end else if (i_shift && !w_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  assign o_hist          = r_hist;
  assign o_full          = w_full;
  assign o_full_on_shift = w_full | (r_fill == FILL_W'(N - 1));

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial bit-pattern detector: compares the last N accepted bits of din with a
// run-time loadable pattern and emits a registered one-cycle match pulse.
// Optional feature macro: SEQ_DETECT_CNT_EN builds the saturating match
// counter; without it match_cnt is tied to zero (ports are identical).
// Parameters:
//   N       : pattern length, N_MIN..N_MAX (2..32)
//   PAT_RST : pattern value after reset
//   CNT_W   : match counter width
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   din       : serial data bit
//   din_valid : din accepted on this edge
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   pat_load  : load pat_in into the pattern register (overrides din_valid)
//   pat_in    : new pattern, first-received bit in the MSB
//   d_out     : registered match pulse
//   match_cnt : saturating match count
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned   N       = 4,
  parameter logic [N-1:0]  PAT_RST = N'(PAT_DEFAULT),
  parameter int unsigned   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             d_out,
  output logic [CNT_W-1:0] match_cnt
);

  mode_e        w_mode;
  logic         w_accept;
  logic         w_clear;
  logic         w_match;
  logic [N-1:0] w_hist;
  logic [N-1:0] w_hist_n;
  logic         w_full;
  logic         w_full_on_shift;

  logic [N-1:0] r_pat;
  logic         r_d_out;

  assign w_mode   = mode_e'(overlap);
  assign w_accept = din_valid & ~pat_load;
  assign w_hist_n = {w_hist[N-2:0], din};

  // Match is judged on the history as it will be after this bit lands, so the
  // pulse can be registered on the same edge that accepts the bit.
  assign w_match  = w_accept & w_full_on_shift & (w_hist_n == r_pat);

  // Non-overlap mode restarts the fill count after a match; a pattern load
  // discards any partial history.
  assign w_clear  = pat_load | (w_match & (w_mode == NON_OVERLAP));

  seq_hist_shift #(
    .N (N)
  ) u_hist (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_shift         (w_accept),
    .i_clear         (w_clear),
    .i_din           (din),
    .o_hist          (w_hist),
    .o_full          (w_full),
    .o_full_on_shift (w_full_on_shift)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= PAT_RST;
    end else if (pat_load) begin
      r_pat <= pat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= 1'b0;
    end else begin
      r_d_out <= w_match;
    end
  end

  assign d_out = r_d_out;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       d_out;
  logic [1:0] match_cnt;

  always #5 clk = ~clk;

  seq_detect_param #(
    .N       (4),
    .PAT_RST (4'b1001),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .d_out     (d_out),
    .match_cnt (match_cnt)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  typedef struct packed {
    logic       d;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  logic [3:0] m_hist = 4'b0000;
  logic [3:0] m_pat  = 4'b1001;
  int         m_fill = 0;
  int         m_cnt  = 0;

  function automatic logic [1:0] exp_cnt(input int n);
`ifdef SEQ_DETECT_CNT_EN
    return (n > 3) ? 2'd3 : 2'(n);
`else
    return 2'd0;
`endif
  endfunction

  // Drive one cycle of inputs and push the expected output of that edge.
  task automatic drive(input logic rst, input logic pl, input logic [3:0] pi,
                       input logic v, input logic b, input logic ov);
    exp_t e;
    @(negedge clk);
    reset = rst; pat_load = pl; pat_in = pi; din_valid = v; din = b; overlap = ov;
    e.d = 1'b0;
    if (rst) begin
      m_hist = 4'b0000; m_fill = 0; m_pat = 4'b1001; m_cnt = 0;
    end else if (pl) begin
      m_pat = pi; m_fill = 0;
    end else if (v) begin
      m_hist = {m_hist[2:0], b};
      if (m_fill < 4) m_fill++;
      if (m_fill == 4 && m_hist == m_pat) begin
        e.d = 1'b1;
        if (!ov) m_fill = 0;
        if (m_cnt < 3) m_cnt++;
      end
    end
    e.cnt = exp_cnt(m_cnt);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #2;
    pulse_cnt = 0;
  endtask

  task automatic bit_in(input logic b, input logic ov);
    drive(1'b0, 1'b0, 4'b0000, 1'b1, b, ov);
  endtask

  task automatic stream(input logic [15:0] bits, input int len, input logic ov);
    for (int i = len - 1; i >= 0; i--) bit_in(bits[i], ov);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  // Scoreboard: compare every DUT output cycle against the model.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (d_out !== mon_e.d || match_cnt !== mon_e.cnt) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t d_out=%b match_cnt=%0d expected d_out=%b match_cnt=%0d",
                 $time, d_out, match_cnt, mon_e.d, mon_e.cnt);
      end
      if (d_out === 1'b1) pulse_cnt++;
    end
  end

  task automatic test_reset();
    // Reset must win over a simultaneous pattern load and valid bit.
    drive(1'b1, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1);
    settle();
    pulse_cnt = 0;
    n_tests++;
    if (d_out !== 1'b0 || match_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state d_out=%b match_cnt=%0d expected 0/0", d_out, match_cnt);
    end
    stream(16'b1001, 4, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 1) begin
      n_fail++;
      $display("FAIL reset_pattern pulses=%0d expected 1", pulse_cnt);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    stream(16'b1001001, 7, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 2 || match_cnt !== exp_cnt(2)) begin
      n_fail++;
      $display("FAIL overlap pulses=%0d cnt=%0d expected 2/%0d", pulse_cnt, match_cnt, exp_cnt(2));
    end
  endtask

  task automatic test_non_overlap();
    do_reset();
    stream(16'b1001001, 7, 1'b0);
    settle();
    n_tests++;
    if (pulse_cnt !== 1 || match_cnt !== exp_cnt(1)) begin
      n_fail++;
      $display("FAIL non_overlap pulses=%0d cnt=%0d expected 1/%0d", pulse_cnt, match_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_gaps();
    do_reset();
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 1 || match_cnt !== exp_cnt(1)) begin
      n_fail++;
      $display("FAIL gaps pulses=%0d cnt=%0d expected 1/%0d", pulse_cnt, match_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_pat_load();
    do_reset();
    drive(1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1);
    stream(16'b1110, 4, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 1) begin
      n_fail++;
      $display("FAIL pat_load_new pulses=%0d expected 1", pulse_cnt);
    end
    pulse_cnt = 0;
    stream(16'b1001, 4, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 0) begin
      n_fail++;
      $display("FAIL pat_load_old pulses=%0d expected 0", pulse_cnt);
    end
    // The bit offered with the load is dropped, so 1,1,0 afterwards is short.
    drive(1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1);
    stream(16'b110, 3, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 0) begin
      n_fail++;
      $display("FAIL pat_load_drop pulses=%0d expected 0", pulse_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stream(16'b100, 3, 1'b1);
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 0 || match_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid pulses=%0d cnt=%0d expected 0/0", pulse_cnt, match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    stream(16'b11111, 5, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 2) begin
      n_fail++;
      $display("FAIL back_to_back pulses=%0d expected 2", pulse_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stream(16'b1001001001001001, 16, 1'b1);
    settle();
    n_tests++;
    if (pulse_cnt !== 5 || match_cnt !== exp_cnt(5)) begin
      n_fail++;
      $display("FAIL saturation pulses=%0d cnt=%0d expected 5/%0d", pulse_cnt, match_cnt, exp_cnt(5));
    end
  endtask

  task automatic test_random();
    int r;
    logic ov;
    ov = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) ov = ~ov;
      if (r == 99)
        drive(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, ov);
      else if (r < 3)
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), r[0], 1'b1, ov);
      else
        drive(1'b0, 1'b0, 4'b0000, (r % 4) != 0, r[1] ^ r[4], ov);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_pat_load();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_random();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
